// File: rtl/core_sequencer.sv
// Multi-cycle RV32I sequencer: owns pc/IR and steps each instruction through
// fetch, decode, execute, optional memory access and writeback.
//
// state   | meaning
// FETCH   | request instruction at pc, wait for imem_ack
// DECODE  | register file reads operands
// EXECUTE | resolve next_pc, check alignment
// MEM     | data access, wait for dmem_ack
// WB      | commit pc, pulse reg_write_en/retire
// ERROR   | sticky halt, only rst exits
module core_sequencer #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic                  Load,
    input  logic                  Store,
    input  logic                  Branch,
    input  logic                  next_sel,
    input  logic                  Jalr,
    input  logic                  branch_result,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ack,
    output logic                  reg_write_en,
    output logic                  retire,
    output logic [31:0]           instret,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_ERROR
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   pc_q;
    logic [DATA_WIDTH-1:0]   next_pc_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic [31:0]             instret_q;
    logic [CW-1:0]           wait_q;
    logic                    imem_req_q;
    logic                    dmem_req_q;
    logic                    dmem_we_q;
    logic                    reg_write_en_q;
    logic                    retire_q;
    logic                    error_q;
    logic [1:0]              err_code_q;

    logic [DATA_WIDTH-1:0]   next_pc_d;
    logic                    misaligned_d;
    logic                    writes_rd_d;

    always_comb begin
        next_pc_d = pc_q + DATA_WIDTH'(4);
        if (next_sel || Jalr) begin
            next_pc_d = alu_result;
            if (Jalr) begin
                next_pc_d[0] = 1'b0;
            end
        end else if (Branch && branch_result) begin
            next_pc_d = alu_result;
        end
        misaligned_d = |next_pc_d[1:0];
        writes_rd_d  = !(Store || Branch);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            next_pc_q      <= RESET_PC;
            instr_q        <= '0;
            instret_q      <= '0;
            wait_q         <= '0;
            imem_req_q     <= 1'b0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            reg_write_en_q <= 1'b0;
            retire_q       <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= 2'b00;
        end else begin
            reg_write_en_q <= 1'b0;
            retire_q       <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    // First cycle out of reset raises the request; acks count only once it is up.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                        wait_q     <= '0;
                    end else if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        imem_req_q <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= 2'b01;
                        state_q    <= S_ERROR;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    next_pc_q <= next_pc_d;
                    if (misaligned_d) begin
                        error_q    <= 1'b1;
                        err_code_q <= 2'b11;
                        state_q    <= S_ERROR;
                    end else if (Load || Store) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= Store;
                        wait_q     <= '0;
                        state_q    <= S_MEM;
                    end else begin
                        reg_write_en_q <= writes_rd_d;
                        retire_q       <= 1'b1;
                        state_q        <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q     <= 1'b0;
                        dmem_we_q      <= 1'b0;
                        reg_write_en_q <= writes_rd_d;
                        retire_q       <= 1'b1;
                        state_q        <= S_WB;
                    end else if (wait_q == WAIT_LAST) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= 2'b10;
                        state_q    <= S_ERROR;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WB: begin
                    pc_q       <= next_pc_q;
                    instret_q  <= instret_q + 32'd1;
                    wait_q     <= '0;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_ERROR: begin
                    state_q <= S_ERROR;
                end
                default: begin
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                    error_q    <= 1'b1;
                    err_code_q <= 2'b11;
                    state_q    <= S_ERROR;
                end
            endcase
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_q;
    assign instruction  = instr_q;
    assign pc           = pc_q;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign reg_write_en = reg_write_en_q;
    assign retire       = retire_q;
    assign instret      = instret_q;
    assign error        = error_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: each instruction is a transaction whose address,
// length, strobes and outcome are predicted from the sequencing rules.
module tb_core_sequencer;

    localparam int          TO  = 16;
    localparam logic [31:0] RPC = 32'h0000_0000;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_JALR = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        Load = 1'b0, Store = 1'b0, Branch = 1'b0;
    logic        next_sel = 1'b0, Jalr = 1'b0, branch_result = 1'b0;
    logic [31:0] alu_result = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        reg_write_en;
    logic        retire;
    logic [31:0] instret;
    logic        error;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instret;

    core_sequencer #(.DATA_WIDTH(32), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .pc(pc),
        .Load(Load), .Store(Store), .Branch(Branch), .next_sel(next_sel), .Jalr(Jalr),
        .branch_result(branch_result), .alu_result(alu_result),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_write_en(reg_write_en), .retire(retire), .instret(instret),
        .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        {Load, Store, Branch, next_sel, Jalr, branch_result} = '0;
        repeat (2) @(negedge clk);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_pc", pc, RPC);
        check("rst_ir", instruction, 0);
        check("rst_instret", instret, 0);
        check("rst_error", {error, err_code}, 0);
        check("rst_strobes", {dmem_we, reg_write_en, retire}, 0);
        rst = 1'b1;
        m_pc = RPC;
        m_instret = 0;
    endtask

    task automatic do_instr(input int kind, input int iw, input int dw,
                            input logic [31:0] alu, input logic taken, input bit abort);
        logic [31:0] word, exp_next, pc_hold;
        logic [1:0]  exp_err;
        bit          is_mem, is_store, writes, mis, acked_i, done;
        int          n, cyc, ic, dc, rwe, ret, we_bad;

        word     = $urandom();
        is_store = (kind == K_STORE);
        is_mem   = (kind == K_LOAD) || is_store;
        writes   = !(is_store || kind == K_BR);
        case (kind)
            K_JAL:   exp_next = alu;
            K_JALR:  exp_next = {alu[31:1], 1'b0};
            K_BR:    exp_next = taken ? alu : m_pc + 32'd4;
            default: exp_next = m_pc + 32'd4;
        endcase
        mis = (exp_next % 4) != 0;
        if (iw >= TO)                 exp_err = 2'b01;
        else if (mis)                 exp_err = 2'b11;
        else if (is_mem && dw >= TO)  exp_err = 2'b10;
        else                          exp_err = 2'b00;

        // Flags belong to the previous IR until the fetch completes.
        {Load, Store, Branch, next_sel, Jalr, branch_result} = 6'($urandom());
        alu_result = $urandom();

        n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("fetch_addr", imem_addr, m_pc);

        cyc = 0; ic = 0; dc = 0; rwe = 0; ret = 0; we_bad = 0;
        acked_i = 0; done = 0;
        while (!done && cyc < 200) begin
            if (acked_i) begin
                check("ir_latch", instruction, word);
                acked_i = 0;
            end
            cyc++;
            if (imem_req) begin
                ic++;
                if (ic == iw + 1) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word;
                    acked_i    = 1;
                    Load          = (kind == K_LOAD);
                    Store         = is_store;
                    Branch        = (kind == K_BR);
                    branch_result = taken;
                    next_sel      = (kind == K_JAL);
                    Jalr          = (kind == K_JALR);
                    alu_result    = alu;
                end
            end else begin
                imem_ack = 1'($urandom());
            end
            if (dmem_req) begin
                dc++;
                if (dmem_we !== is_store) we_bad++;
                if (abort && dc == 3) begin
                    rst  = 1'b0;
                    done = 1;
                end else if (dc == dw + 1) begin
                    dmem_ack = 1'b1;
                end
            end else begin
                dmem_ack = 1'($urandom());
            end
            if (reg_write_en) rwe++;
            if (retire) ret++;
            if (retire || error) done = 1;
            @(negedge clk);
            imem_ack   = 1'b0;
            dmem_ack   = 1'b0;
            imem_rdata = $urandom();
        end
        if (!done) check("instr_budget", 0, 1);

        if (abort) begin
            check("abort_dmem_req", dmem_req, 0);
            check("abort_pc", pc, RPC);
            check("abort_instret", instret, 0);
            check("abort_strobes", {reg_write_en, retire}, 0);
            check("abort_no_commit", rwe + ret, 0);
            rst = 1'b1;
            m_pc = RPC;
            m_instret = 0;
        end else if (exp_err != 2'b00) begin
            check("err_flag", error, 1);
            check("err_code", err_code, exp_err);
            check("err_no_commit", rwe + ret, 0);
            if (exp_err == 2'b01) check("imem_timeout_len", ic, TO);
            if (exp_err == 2'b10) check("dmem_timeout_len", dc, TO);
            pc_hold = pc;
            repeat (5) begin
                imem_ack = 1'($urandom());
                dmem_ack = 1'($urandom());
                @(negedge clk);
            end
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            check("err_pc_frozen", pc, m_pc);
            check("err_pc_hold", pc, pc_hold);
            check("err_instret_frozen", instret, m_instret);
            check("err_quiet", {imem_req, dmem_req, reg_write_en, retire}, 0);
            check("err_sticky", {error, err_code}, {1'b1, exp_err});
            do_reset();
        end else begin
            check("instr_cycles", cyc, 4 + iw + (is_mem ? dw + 1 : 0));
            check("imem_req_cycles", ic, iw + 1);
            check("dmem_req_cycles", dc, is_mem ? dw + 1 : 0);
            check("dmem_we", we_bad, 0);
            check("reg_write_en", rwe, writes ? 1 : 0);
            check("retire", ret, 1);
            check("instret", instret, m_instret + 32'd1);
            check("next_addr", imem_addr, exp_next);
            m_pc = exp_next;
            m_instret = m_instret + 32'd1;
        end
    endtask

    initial begin
        int kind, iw, dw;
        logic [31:0] alu;

        @(negedge clk);
        do_reset();

        // Straight-line stream from reset, then branches and memory ops.
        repeat (3) do_instr(K_ALU, 0, 0, 32'h0, 1'b0, 0);
        check("instret_after_3", instret, 3);
        do_instr(K_ALU, 0, 0, 32'h0, 1'b0, 0);
        do_instr(K_BR, 0, 0, 32'h40, 1'b1, 0);
        do_instr(K_BR, 0, 0, 32'h80, 1'b0, 0);
        do_instr(K_LOAD, 0, 3, 32'h1000, 1'b0, 0);
        do_instr(K_STORE, 1, 0, 32'h1004, 1'b0, 0);
        do_instr(K_JAL, 0, 0, 32'hFFFF_FFFC, 1'b0, 0);
        do_instr(K_ALU, 0, 0, 32'h0, 1'b0, 0);
        check("pc_wrap", pc, 0);
        do_instr(K_ALU, TO - 1, 0, 32'h0, 1'b0, 0);
        do_instr(K_LOAD, 0, TO - 1, 32'h0, 1'b0, 0);
        do_instr(K_ALU, TO, 0, 32'h0, 1'b0, 0);
        do_instr(K_STORE, 0, TO, 32'h0, 1'b0, 0);
        do_instr(K_JALR, 0, 0, 32'h103, 1'b0, 0);
        do_instr(K_JALR, 0, 0, 32'h201, 1'b0, 0);
        do_instr(K_ALU, 0, 0, 32'h0, 1'b0, 0);
        do_instr(K_LOAD, 0, 10, 32'h0, 1'b0, 1);
        do_instr(K_ALU, 0, 0, 32'h0, 1'b0, 0);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 5);
            iw   = ($urandom_range(0, 15) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 3);
            dw   = ($urandom_range(0, 15) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 3);
            alu  = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) alu = alu | 32'($urandom_range(1, 3));
            do_instr(kind, iw, dw, alu, 1'($urandom()), ($urandom_range(0, 19) == 0) && kind == K_LOAD && dw > 3 && iw < TO);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle sequencer for the RV32I core: owns the program counter and instruction register, and walks each instruction through fetch, decode, execute, optional memory access and writeback. It drives instruction and data memory request/acknowledge handshakes and gates register-file writes. It consumes the decode-stage control flags (Load, Store, Branch, next_sel, Jalr, branch_result) and the ALU result. It detects bus timeouts and misaligned control-flow targets, then halts in a sticky error state.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath/address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT, 16, maximum wait cycles per memory handshake (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- imem_req  out  1  instruction fetch request
- imem_addr  out  DATA_WIDTH  fetch address (= pc)
- imem_ack  in  1  fetch data valid
- imem_rdata  in  DATA_WIDTH  fetched instruction word
- instruction  out  DATA_WIDTH  instruction register, feeds decode
- pc  out  DATA_WIDTH  current instruction address
- Load, Store, Branch, next_sel, Jalr  in  1 each  decoded control flags for current IR
- branch_result  in  1  branch condition true
- alu_result  in  DATA_WIDTH  ALU output (branch/jump target when control flow)
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  in  1  data access complete
- reg_write_en  out  1  register-file write strobe
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  32  retired-instruction counter
- error  out  1  sticky fault flag
- err_code  out  2  01 imem timeout, 10 dmem timeout, 11 misaligned target

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, ERROR.
- Reset state: FETCH, with pc=RESET_PC, instruction=0, instret=0, wait counter=0, error=0, err_code=00.
- Reset values of all strobes: imem_req=0, dmem_req=0, dmem_we=0, reg_write_en=0, retire=0.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack, latch imem_rdata into instruction and go to DECODE.
- DECODE: one cycle; the register file reads operands.
- EXECUTE: one cycle.
  - Computes next_pc:
    - next_sel or Jalr: alu_result, with bit0 cleared when Jalr.
    - Branch && branch_result: alu_result.
    - Otherwise: pc+4, modulo 2^32 (wraps at 0xFFFF_FFFC to 0).
  - If next_pc[1:0] != 00, go to ERROR with err_code=11.
  - Otherwise go to MEM if Load|Store, else WB.
- MEM:
  - dmem_req=1, dmem_we=Store.
  - Held until dmem_ack, then go to WB.
- WB: one cycle.
  - pc ← next_pc.
  - reg_write_en=1 unless Store or Branch; JAL/JALR write (link value is the datapath's concern).
  - retire=1, instret+1 (wraps at 2^32−1 to 0).
  - Next state: FETCH.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and increments each cycle the ack is low.
  - An ack sampled while counter==TIMEOUT−1 is accepted.
  - Counter==TIMEOUT−1 with no ack goes to ERROR: err_code=01 from FETCH, 10 from MEM.
- ERROR:
  - All requests and strobes are 0; pc, instruction and instret are frozen; error=1.
  - Only rst exits.
- imem_ack/dmem_ack outside their request state are ignored.
- Control flags are only sampled in EXECUTE/MEM/WB. Flags are decoded from the held IR, so they are stable.

## Timing
- Non-memory instruction, ack in first request cycle: 4 cycles (FETCH, DECODE, EXECUTE, WB); retire once per 4 cycles.
- Load/store with immediate dmem_ack: 5 cycles.
- Each extra wait cycle on either bus adds exactly one cycle.
- instruction updates the cycle after the ack edge. pc updates on the edge leaving WB, so the next imem_addr shows the new pc in the first FETCH cycle.
- reg_write_en and retire are asserted only during WB, single cycle, same cycle as the pc update edge.
- Reset mid-instruction (any state, including MEM with dmem_req high):
  - The next edge forces reset values.
  - No retire or reg_write_en is produced for the aborted instruction.

## Test plan
- Reset then ADDI stream, imem_ack immediate → imem_addr 0,4,8; retire every 4th cycle; instret=3 after 12 cycles.
- BEQ taken with alu_result=0x40 at pc=0x10 → next imem_addr=0x40, reg_write_en never high. Not taken → 0x14.
- JALR with alu_result=0x103 → pc=0x102, ERROR with err_code=11, error stays 1 until rst=0.
- LW with dmem_ack after 3 wait cycles → dmem_req high 4 cycles, dmem_we=0, 8-cycle instruction, reg_write_en pulse. SW → dmem_we=1, no reg_write_en.
- imem_ack withheld (TIMEOUT=16):
  - ack on cycle 16 → accepted.
  - No ack for 16 cycles → ERROR, err_code=01.
  - Same check on dmem, err_code=10.
- rst=0 during MEM → next cycle: dmem_req=0, pc=RESET_PC, instret unchanged from reset value 0, FETCH resumes after rst=1.
